// File: rtl/press_ctrl_pkg.sv
// Shared types and helpers for the push-button press controller.
//   press_state_t : per-channel press FSM encoding (also the debug encoding)
//   cnt_width()   : width of the saturating per-channel counter
//   params_legal(): elaboration-time parameter sanity check
package press_ctrl_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESS   = 2'd2,
    HELD    = 2'd3
  } press_state_t;

  // Depth of the input synchronizer; LOCKOUT also waits this many cycles
  // so it never judges the button from flops still holding reset zeros.
  localparam int SYNC_STAGES       = 2;
  // A long press must be reachable from cnt=1 with a compare at LONG-1.
  localparam int MIN_LONG_CYCLES   = 2;
  localparam int MIN_REPEAT_CYCLES = 1;

  function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
    int m;
    m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic bit params_legal(input int long_cycles, input int debounce_cycles,
                                      input int repeat_cycles, input int n_btn);
    return (long_cycles >= MIN_LONG_CYCLES) && (debounce_cycles >= 0) &&
           (debounce_cycles < long_cycles) && (repeat_cycles >= MIN_REPEAT_CYCLES) &&
           (n_btn >= 1);
  endfunction

endpackage

// File: rtl/press_channel.sv
// One button channel: 2-flop synchronizer, press FSM and saturating counter.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   btn_i            raw asynchronous button level (1 = pressed)
//   repeat_en_i      enables auto-repeat while held
//   short_o          registered 1-cycle pulse: valid press released early
//   long_o           registered 1-cycle pulse: long threshold reached
//   repeat_o         registered 1-cycle pulse: auto-repeat tick
//   long_set_o       combinational: long_o will be high next cycle
//   state_o          current FSM state (debug)
// Pulse handshake: each pulse output is high for exactly one clock and has
// no ready/acknowledge; the consumer must sample it on that cycle.
module press_channel
  import press_ctrl_pkg::*;
#(
  parameter int LONG_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int REPEAT_CYCLES   = 200,
  parameter int CNT_W           = cnt_width(LONG_CYCLES, REPEAT_CYCLES)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         btn_i,
  input  logic         repeat_en_i,
  output logic         short_o,
  output logic         long_o,
  output logic         repeat_o,
  output logic         long_set_o,
  output press_state_t state_o
);

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] WARM_C  = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic             sync1_q, sync2_q;
  press_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             btn_s;

  assign btn_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      LOCKOUT: begin
        // cnt doubles as the synchronizer warm-up timer after reset.
        if (cnt_q < WARM_C) begin
          cnt_d = cnt_q + ONE_C;
        end else if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS;
          cnt_d   = ONE_C;
        end
      end
      PRESS: begin
        if (btn_s) begin
          if (cnt_q == LONG_M1) begin
            long_d  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + ONE_C;
          end
        end else begin
          short_d = (cnt_q >= DEB_C);
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          cnt_d = '0;
        end else if (cnt_q == REP_M1) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = LOCKOUT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOCKOUT;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign short_o    = short_q;
  assign long_o     = long_q;
  assign repeat_o   = rep_q;
  assign long_set_o = long_d;
  assign state_o    = state_q;

endmodule

// File: rtl/press_event_controller.sv
// Multi-channel push-button controller with a config latch on long press.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   btn           raw button levels, 1 = pressed
//   repeat_en     enables auto-repeat pulses on all channels
//   cfg_in        config word sampled on a long press
//   short_push    per-channel 1-cycle short press pulse
//   long_push     per-channel 1-cycle long press pulse
//   repeat_push   per-channel 1-cycle auto-repeat pulse
//   cfg_latched   copy of cfg_in captured on the cycle long_push rises
//   cfg_valid     sticky, set by the first latch
//   latch_src     lowest channel index that caused the latest latch
//   state_dbg     per-channel FSM state, 2 bits per channel (debug)
module press_event_controller
  import press_ctrl_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int N_BTN           = 5,
  parameter int LONG_CYCLES     = CLK_FREQ,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
  parameter int REPEAT_CYCLES   = CLK_FREQ / 5,
  parameter int CFG_W           = 12
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [N_BTN-1:0]                           btn,
  input  logic                                       repeat_en,
  input  logic [CFG_W-1:0]                           cfg_in,
  output logic [N_BTN-1:0]                           short_push,
  output logic [N_BTN-1:0]                           long_push,
  output logic [N_BTN-1:0]                           repeat_push,
  output logic [CFG_W-1:0]                           cfg_latched,
  output logic                                       cfg_valid,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] latch_src,
  output logic [2*N_BTN-1:0]                         state_dbg
);

  localparam int SRC_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

  if (!params_legal(LONG_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES, N_BTN)) begin : g_bad_params
    $error("press_event_controller: illegal LONG/DEBOUNCE/REPEAT/N_BTN combination");
  end

  logic [N_BTN-1:0] long_set;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    press_state_t st_w;
    press_channel #(
      .LONG_CYCLES    (LONG_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (reset),
      .btn_i      (btn[g]),
      .repeat_en_i(repeat_en),
      .short_o    (short_push[g]),
      .long_o     (long_push[g]),
      .repeat_o   (repeat_push[g]),
      .long_set_o (long_set[g]),
      .state_o    (st_w)
    );
    assign state_dbg[2*g +: 2] = st_w;
  end

  // Latch on the same edge that raises long_push, so the channels' next-state
  // long flags are used rather than the registered pulses.
  logic [SRC_W-1:0] src_d;
  always_comb begin
    src_d = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (long_set[i]) src_d = SRC_W'(i);
    end
  end

  logic [CFG_W-1:0] cfg_q;
  logic             valid_q;
  logic [SRC_W-1:0] src_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
    end else if (|long_set) begin
      cfg_q   <= cfg_in;
      valid_q <= 1'b1;
      src_q   <= src_d;
    end
  end

  assign cfg_latched = cfg_q;
  assign cfg_valid   = valid_q;
  assign latch_src   = src_q;

endmodule

// File: tb/tb_press_event_controller.sv
module tb_press_event_controller;

  localparam int N     = 5;
  localparam int CFG_W = 12;

  logic             clk;
  logic             reset;
  logic [N-1:0]     btn;
  logic             repeat_en;
  logic [CFG_W-1:0] cfg_in;
  logic [N-1:0]     short_push, long_push, repeat_push;
  logic [CFG_W-1:0] cfg_latched;
  logic             cfg_valid;
  logic [2:0]       latch_src;
  logic [2*N-1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  press_event_controller #(
    .CLK_FREQ(1000), .N_BTN(N), .LONG_CYCLES(1000), .DEBOUNCE_CYCLES(10),
    .REPEAT_CYCLES(200), .CFG_W(CFG_W)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .repeat_en(repeat_en), .cfg_in(cfg_in),
    .short_push(short_push), .long_push(long_push), .repeat_push(repeat_push),
    .cfg_latched(cfg_latched), .cfg_valid(cfg_valid), .latch_src(latch_src),
    .state_dbg(state_dbg)
  );

  // ---------------- pulse recorder ----------------
  // rel counts clock edges since the stimulus start; all *_at are in that frame.
  int       rel;
  int       n_long[N], n_short[N], n_rep[N];
  int       long_at[N], short_at[N], short_last[N], rep_first[N], rep_last[N];
  int       valid_at, overlap_n;
  logic [N-1:0] long_vec_first;

  task automatic clear_rec();
    rel = 0; valid_at = -1; overlap_n = 0; long_vec_first = '0;
    for (int i = 0; i < N; i++) begin
      n_long[i] = 0; n_short[i] = 0; n_rep[i] = 0;
      long_at[i] = -1; short_at[i] = -1; short_last[i] = -1;
      rep_first[i] = -1; rep_last[i] = -1;
    end
  endtask

  task automatic tick_rec();
    @(posedge clk);
    #1;
    rel++;
    for (int i = 0; i < N; i++) begin
      if (long_push[i]) begin n_long[i]++; if (long_at[i] < 0) long_at[i] = rel; end
      if (short_push[i]) begin
        n_short[i]++; short_last[i] = rel;
        if (short_at[i] < 0) short_at[i] = rel;
      end
      if (repeat_push[i]) begin
        n_rep[i]++; rep_last[i] = rel;
        if (rep_first[i] < 0) rep_first[i] = rel;
      end
    end
    if ((long_push != '0) && (long_vec_first == '0)) long_vec_first = long_push;
    if (cfg_valid && (valid_at < 0)) valid_at = rel;
    if (((long_push & short_push) | (long_push & repeat_push) | (short_push & repeat_push)) != '0)
      overlap_n++;
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < N; i++) s += n_long[i] + n_short[i] + n_rep[i];
    return s;
  endfunction

  // Drive mask for `hold` edges, release, then observe `tail` more edges.
  task automatic press_window(input logic [N-1:0] mask, input int hold, input int tail);
    clear_rec();
    btn = mask;
    repeat (hold) tick_rec();
    btn = '0;
    repeat (tail) tick_rec();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; btn = '0; repeat_en = 1'b0; cfg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (short_push !== 5'b0) begin n_bad++; $display("FAIL reset_short got=%b exp=0", short_push); end
    n_cmp++; if (long_push !== 5'b0) begin n_bad++; $display("FAIL reset_long got=%b exp=0", long_push); end
    n_cmp++; if (repeat_push !== 5'b0) begin n_bad++; $display("FAIL reset_repeat got=%b exp=0", repeat_push); end
    n_cmp++; if (cfg_latched !== 12'h000) begin n_bad++; $display("FAIL reset_cfg got=%h exp=000", cfg_latched); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", cfg_valid); end
    n_cmp++; if (latch_src !== 3'd0) begin n_bad++; $display("FAIL reset_src got=%0d exp=0", latch_src); end
    n_cmp++; if (state_dbg !== 10'h000) begin n_bad++; $display("FAIL reset_state got=%h exp=000", state_dbg); end
    reset = 1'b0;
    repeat (5) tick_rec();
    // All channels released: LOCKOUT -> IDLE (2'b01 each).
    n_cmp++; if (state_dbg !== 10'h155) begin n_bad++; $display("FAIL rearm_state got=%h exp=155", state_dbg); end
  endtask

  task automatic test_long();
    cfg_in = 12'h1A3; repeat_en = 1'b0;
    press_window(5'b00001, 1100, 10);
    cfg_in = 12'h7E7;
    n_cmp++; if (n_long[0] !== 1) begin n_bad++; $display("FAIL long_count got=%0d exp=1", n_long[0]); end
    n_cmp++; if (long_at[0] !== 1002) begin n_bad++; $display("FAIL long_latency got=%0d exp=1002", long_at[0]); end
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL long_other_pulses got=%0d exp=1", total_pulses()); end
    n_cmp++; if (cfg_latched !== 12'h1A3) begin n_bad++; $display("FAIL long_cfg got=%h exp=1a3", cfg_latched); end
    n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL long_valid got=%b exp=1", cfg_valid); end
    n_cmp++; if (latch_src !== 3'd0) begin n_bad++; $display("FAIL long_src got=%0d exp=0", latch_src); end
    n_cmp++; if (valid_at !== 1002) begin n_bad++; $display("FAIL long_valid_at got=%0d exp=1002", valid_at); end
  endtask

  task automatic test_short();
    press_window(5'b00100, 500, 10);
    n_cmp++; if (n_short[2] !== 1) begin n_bad++; $display("FAIL short_count got=%0d exp=1", n_short[2]); end
    n_cmp++; if (short_at[2] !== 503) begin n_bad++; $display("FAIL short_latency got=%0d exp=503", short_at[2]); end
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL short_other_pulses got=%0d exp=1", total_pulses()); end
    n_cmp++; if (cfg_latched !== 12'h1A3) begin n_bad++; $display("FAIL short_cfg got=%h exp=1a3", cfg_latched); end
    n_cmp++; if (latch_src !== 3'd0) begin n_bad++; $display("FAIL short_src got=%0d exp=0", latch_src); end
  endtask

  task automatic test_glitch();
    press_window(5'b10000, 5, 10);
    n_cmp++; if (total_pulses() !== 0) begin n_bad++; $display("FAIL glitch_pulses got=%0d exp=0", total_pulses()); end
  endtask

  task automatic test_thresholds();
    // 9 synced-high cycles: below debounce.
    press_window(5'b01000, 9, 10);
    n_cmp++; if (total_pulses() !== 0) begin n_bad++; $display("FAIL deb9_pulses got=%0d exp=0", total_pulses()); end
    // Exactly DEBOUNCE cycles: short.
    press_window(5'b01000, 10, 10);
    n_cmp++; if (short_at[3] !== 13) begin n_bad++; $display("FAIL deb10_short_at got=%0d exp=13", short_at[3]); end
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL deb10_pulses got=%0d exp=1", total_pulses()); end
    // One cycle short of LONG: still a short press.
    press_window(5'b00100, 999, 10);
    n_cmp++; if (short_at[2] !== 1002) begin n_bad++; $display("FAIL long999_short_at got=%0d exp=1002", short_at[2]); end
    n_cmp++; if (n_long[2] !== 0) begin n_bad++; $display("FAIL long999_long got=%0d exp=0", n_long[2]); end
    // Exactly LONG: long, no short on release.
    cfg_in = 12'h0F0;
    press_window(5'b00100, 1000, 10);
    n_cmp++; if (long_at[2] !== 1002) begin n_bad++; $display("FAIL long1000_at got=%0d exp=1002", long_at[2]); end
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL long1000_pulses got=%0d exp=1", total_pulses()); end
    n_cmp++; if (latch_src !== 3'd2) begin n_bad++; $display("FAIL long1000_src got=%0d exp=2", latch_src); end
    n_cmp++; if (cfg_latched !== 12'h0F0) begin n_bad++; $display("FAIL long1000_cfg got=%h exp=0f0", cfg_latched); end
  endtask

  task automatic test_repeat();
    cfg_in = 12'h2C4; repeat_en = 1'b1;
    press_window(5'b00010, 1500, 10);
    n_cmp++; if (long_at[1] !== 1002) begin n_bad++; $display("FAIL rep_long_at got=%0d exp=1002", long_at[1]); end
    n_cmp++; if (n_rep[1] !== 2) begin n_bad++; $display("FAIL rep_count got=%0d exp=2", n_rep[1]); end
    n_cmp++; if (rep_first[1] !== 1202) begin n_bad++; $display("FAIL rep_first got=%0d exp=1202", rep_first[1]); end
    n_cmp++; if (rep_last[1] !== 1402) begin n_bad++; $display("FAIL rep_last got=%0d exp=1402", rep_last[1]); end
    n_cmp++; if (total_pulses() !== 3) begin n_bad++; $display("FAIL rep_total got=%0d exp=3", total_pulses()); end
    n_cmp++; if (overlap_n !== 0) begin n_bad++; $display("FAIL rep_overlap got=%0d exp=0", overlap_n); end
    n_cmp++; if (latch_src !== 3'd1) begin n_bad++; $display("FAIL rep_src got=%0d exp=1", latch_src); end
    n_cmp++; if (cfg_latched !== 12'h2C4) begin n_bad++; $display("FAIL rep_cfg got=%h exp=2c4", cfg_latched); end
    // Same hold with repeat disabled: long only.
    repeat_en = 1'b0;
    press_window(5'b10000, 1500, 10);
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL norep_total got=%0d exp=1", total_pulses()); end
    n_cmp++; if (long_at[4] !== 1002) begin n_bad++; $display("FAIL norep_long_at got=%0d exp=1002", long_at[4]); end
  endtask

  task automatic test_simultaneous();
    cfg_in = 12'h055; repeat_en = 1'b0;
    press_window(5'b01010, 1100, 10);
    n_cmp++; if (long_vec_first !== 5'b01010) begin n_bad++; $display("FAIL sim_vec got=%b exp=01010", long_vec_first); end
    n_cmp++; if (long_at[3] !== 1002) begin n_bad++; $display("FAIL sim_long3_at got=%0d exp=1002", long_at[3]); end
    n_cmp++; if (total_pulses() !== 2) begin n_bad++; $display("FAIL sim_total got=%0d exp=2", total_pulses()); end
    n_cmp++; if (latch_src !== 3'd1) begin n_bad++; $display("FAIL sim_src got=%0d exp=1", latch_src); end
    n_cmp++; if (cfg_latched !== 12'h055) begin n_bad++; $display("FAIL sim_cfg got=%h exp=055", cfg_latched); end
  endtask

  task automatic test_back_to_back();
    clear_rec();
    btn = 5'b00100;
    repeat (20) tick_rec();
    btn = '0;
    repeat (5) tick_rec();
    btn = 5'b00100;
    repeat (20) tick_rec();
    btn = '0;
    repeat (10) tick_rec();
    n_cmp++; if (n_short[2] !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", n_short[2]); end
    n_cmp++; if (short_at[2] !== 23) begin n_bad++; $display("FAIL b2b_first got=%0d exp=23", short_at[2]); end
    n_cmp++; if (short_last[2] !== 48) begin n_bad++; $display("FAIL b2b_second got=%0d exp=48", short_last[2]); end
  endtask

  task automatic test_reset_mid_press();
    clear_rec();
    btn = 5'b00001;
    repeat (600) tick_rec();
    n_cmp++; if (total_pulses() !== 0) begin n_bad++; $display("FAIL rmp_pre_pulses got=%0d exp=0", total_pulses()); end
    reset = 1'b1;
    #1;
    n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL rmp_async_valid got=%b exp=0", cfg_valid); end
    n_cmp++; if (state_dbg[1:0] !== 2'b00) begin n_bad++; $display("FAIL rmp_state got=%b exp=00", state_dbg[1:0]); end
    tick_rec();
    reset = 1'b0;
    clear_rec();
    repeat (1400) tick_rec();
    n_cmp++; if (total_pulses() !== 0) begin n_bad++; $display("FAIL rmp_held_pulses got=%0d exp=0", total_pulses()); end
    n_cmp++; if (valid_at !== -1) begin n_bad++; $display("FAIL rmp_valid_at got=%0d exp=-1", valid_at); end
    n_cmp++; if (cfg_latched !== 12'h000) begin n_bad++; $display("FAIL rmp_cfg got=%h exp=000", cfg_latched); end
    btn = '0;
    repeat (10) tick_rec();
    cfg_in = 12'h3C3;
    press_window(5'b00001, 1100, 10);
    n_cmp++; if (long_at[0] !== 1002) begin n_bad++; $display("FAIL rmp_long_at got=%0d exp=1002", long_at[0]); end
    n_cmp++; if (valid_at !== 1002) begin n_bad++; $display("FAIL rmp_valid_rise got=%0d exp=1002", valid_at); end
    n_cmp++; if (total_pulses() !== 1) begin n_bad++; $display("FAIL rmp_total got=%0d exp=1", total_pulses()); end
    n_cmp++; if (cfg_latched !== 12'h3C3) begin n_bad++; $display("FAIL rmp_cfg_after got=%h exp=3c3", cfg_latched); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_long();
    test_short();
    test_glitch();
    test_thresholds();
    test_repeat();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
